load_extend_pipe: RTL

- Parametrised successor to the core's byte sign-extension logic.
- Takes raw memory read data plus the load's low address bits, size and signedness. Selects the addressed byte, halfword or word lane, then zero- or sign-extends it to XLEN.
- Sits between the data-memory read port and register writeback.
- Valid/ready on both sides; a two-entry skid buffer gives full throughput with a registered in_ready.

---
 rtl/load_extend_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/load_extend_pipe.sv
// rtl/load_extend_pipe.sv - load lane select and sign/zero extension with a two-entry skid buffer
// Optional alignment checking is enabled by defining LOAD_EXTEND_MISALIGN_EN.
module load_extend_pipe #(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int OFFW = $clog2(LANES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [OFFW-1:0] in_offset,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [6:0]      nbits;
  logic [OFFW-1:0] align_mask;
  logic [OFFW-1:0] eff_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] field_mask;
  logic            field_msb;
  logic            size_illegal;
  logic            misaligned;
  logic [XLEN-1:0] ext_data;
  logic            ext_err;

  logic [XLEN-1:0] m_data, s_data;
  logic            m_err, s_err;
  logic            in_xfer, out_xfer;

  always_comb begin
    nbits        = 7'd8 << in_size;
    align_mask   = OFFW'((1 << in_size) - 1);
    size_illegal = (XLEN == 32) && (in_size == 2'd3);
`ifdef LOAD_EXTEND_MISALIGN_EN
    misaligned   = (in_offset & align_mask) != '0;
    eff_off      = in_offset;
`else
    misaligned   = 1'b0;
    eff_off      = in_offset & ~align_mask;
`endif
    shifted      = in_data >> {eff_off, 3'b000};
    // A field as wide as XLEN shifts the one out, so the mask wraps to all ones.
    field_mask   = (XLEN'(1) << nbits) - XLEN'(1);
    field_msb    = |(shifted & (XLEN'(1) << (nbits - 7'd1)));
    ext_data     = (shifted & field_mask) |
                   ((field_msb && !in_unsigned) ? ~field_mask : '0);
    ext_err      = size_illegal || misaligned;
    if (ext_err) begin
      ext_data = '0;
    end
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_xfer) state_nxt = ONE;
      ONE: begin
        if (in_xfer && !out_ready) begin
          state_nxt = FULL;
        end else if (!in_xfer && out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL:    if (out_xfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs decode the state register only, never out_ready.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data <= '0;
      m_err  <= 1'b0;
      s_data <= '0;
      s_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_data <= ext_data;
            m_err  <= ext_err;
          end
        end
        ONE: begin
          if (in_xfer && out_ready) begin
            m_data <= ext_data;
            m_err  <= ext_err;
          end else if (in_xfer) begin
            s_data <= ext_data;
            s_err  <= ext_err;
          end
        end
        FULL: begin
          if (out_xfer) begin
            m_data <= s_data;
            m_err  <= s_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = m_data;
  assign out_err  = m_err;

endmodule
